// File: rtl/sr_latch_gated.sv
// rtl/sr_latch_gated.sv - enable-gated SR storage bits, clocked, with forbidden-state flag
module sr_latch_gated #(
    parameter int WIDTH     = 1,
    parameter int SR_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic [WIDTH-1:0] inv
);

    logic [WIDTH-1:0] q_q,   q_d;
    logic [WIDTH-1:0] qn_q,  qn_d;
    logic [WIDTH-1:0] inv_q, inv_d;

    always_comb begin
        q_d   = q_q;
        qn_d  = qn_q;
        inv_d = inv_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                case ({s[i], r[i]})
                    2'b01: begin
                        q_d[i]   = 1'b0;
                        qn_d[i]  = 1'b1;
                        inv_d[i] = 1'b0;
                    end
                    2'b10: begin
                        q_d[i]   = 1'b1;
                        qn_d[i]  = 1'b0;
                        inv_d[i] = 1'b0;
                    end
                    2'b11: begin
                        // Any policy other than 1 or 2 behaves like the cross-coupled NOR pair.
                        if (SR_POLICY == 1) begin
                            q_d[i]   = 1'b0;
                            qn_d[i]  = 1'b1;
                            inv_d[i] = 1'b0;
                        end else if (SR_POLICY == 2) begin
                            q_d[i]   = 1'b1;
                            qn_d[i]  = 1'b0;
                            inv_d[i] = 1'b0;
                        end else begin
                            q_d[i]   = 1'b0;
                            qn_d[i]  = 1'b0;
                            inv_d[i] = 1'b1;
                        end
                    end
                    default: begin
                        q_d[i]   = q_q[i];
                        qn_d[i]  = qn_q[i];
                        inv_d[i] = inv_q[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            qn_q  <= '1;
            inv_q <= '0;
        end else begin
            q_q   <= q_d;
            qn_q  <= qn_d;
            inv_q <= inv_d;
        end
    end

    assign q   = q_q;
    assign q_  = qn_q;
    assign inv = inv_q;

endmodule

// File: tb/tb_sr_latch_gated.sv
// tb/tb_sr_latch_gated.sv - scoreboard bench for sr_latch_gated, all three policies side by side
module tb_sr_latch_gated;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] en  = '0;
    logic [3:0] s   = '0;
    logic [3:0] r   = '0;
    logic [3:0] q0, qn0, inv0, q1, qn1, inv1, q2, qn2, inv2;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] q0, qn0, inv0, q1, q2;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    sr_latch_gated #(.WIDTH(4), .SR_POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q0), .q_(qn0), .inv(inv0));
    sr_latch_gated #(.WIDTH(4), .SR_POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q1), .q_(qn1), .inv(inv1));
    sr_latch_gated #(.WIDTH(4), .SR_POLICY(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q2), .q_(qn2), .inv(inv2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " q0"},   q0,   4'b0000);
        chk({tag, " qn0"},  qn0,  4'b1111);
        chk({tag, " inv0"}, inv0, 4'b0000);
        chk({tag, " q1"},   q1,   4'b0000);
        chk({tag, " qn1"},  qn1,  4'b1111);
        chk({tag, " q2"},   q2,   4'b0000);
        chk({tag, " qn2"},  qn2,  4'b1111);
    endtask

    task automatic apply(input logic [3:0] e, sv, rv, eq0, eqn0, einv0, eq1, eq2);
        @(negedge clk);
        en = e;
        s  = sv;
        r  = rv;
        sb.push_back('{cyc + 1, eq0, eqn0, einv0, eq1, eq2});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            errs++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
    endtask

    // Monitor: registered outputs are compared half a cycle after the edge they belong to.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk("q0",   q0,   mon_e.q0);
            chk("qn0",  qn0,  mon_e.qn0);
            chk("inv0", inv0, mon_e.inv0);
            chk("q1",   q1,   mon_e.q1);
            chk("qn1",  qn1,  ~mon_e.q1);
            chk("inv1", inv1, 4'b0000);
            chk("q2",   q2,   mon_e.q2);
            chk("qn2",  qn2,  ~mon_e.q2);
            chk("inv2", inv2, 4'b0000);
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1 chk_reset_state("async rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // gate closed / idle
        repeat (3) apply(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        repeat (2) apply(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        apply(4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        // set, hold, reset, gated hold
        apply(4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
        apply(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
        apply(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        apply(4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        // forbidden input, held, then resolved by set
        apply(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
        apply(4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
        apply(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
        apply(4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
        // forbidden again, resolved by reset
        apply(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
        apply(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        // mixed per-bit
        apply(4'b1011, 4'b0011, 4'b1000, 4'b0011, 4'b1100, 4'b0000, 4'b0011, 4'b0011);
        apply(4'b1111, 4'b0101, 4'b0110, 4'b0001, 4'b1010, 4'b0100, 4'b0001, 4'b0101);
        apply(4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b1010, 4'b0100, 4'b0001, 4'b0101);
        apply(4'b0110, 4'b0100, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b0101, 4'b0101);
        drain();

        // reset mid-cycle, held across an edge with set pending
        @(negedge clk);
        en = 4'hF; s = 4'hF; r = 4'h0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_state("mid rst");
        @(posedge clk);
        #1 chk_reset_state("rst over edge");
        @(negedge clk);
        rst = 1'b0;
        en = 4'h0;
        apply(4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        apply(4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
